// File: rtl/relax_osc_freq_counter_pkg.sv
// Shared types and helpers for the relaxation-oscillator frequency counter.
// Gate windows are powers of two so the measured frequency is a plain shift of the result.
package relax_osc_freq_counter_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  localparam int GATE_SEL_W = 3;
  localparam int BYTE_SEL_W = 2;

  function automatic logic [31:0] gate_len(input logic [GATE_SEL_W-1:0] sel, input int min_log2);
    gate_len = 32'd1 << (min_log2 + int'(sel));
  endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// Brings the asynchronous oscillator into the clk domain and flags each rising edge
// as a single-cycle pulse, SYNC_STAGES+1 cycles after the edge.
module osc_edge_sync
  import relax_osc_freq_counter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic osc_in,
  output logic edge_det
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], osc_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/relax_osc_freq_counter.sv
// Counts oscillator rising edges over a 2^(GATE_MIN_LOG2+gate_sel) cycle gate window
// and holds the last count for byte-wise readout: f_osc = result * f_clk / gate_len.
module relax_osc_freq_counter
  import relax_osc_freq_counter_pkg::*;
#(
  parameter int CNT_W         = 24,
  parameter int GATE_MIN_LOG2 = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  osc_in,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [GATE_SEL_W-1:0] gate_sel,
  input  logic [BYTE_SEL_W-1:0] byte_sel,
  output logic [CNT_W-1:0]      result,
  output logic [7:0]            data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  valid,
  output logic                  overflow
);

  localparam int TMR_W = GATE_MIN_LOG2 + (1 << GATE_SEL_W) - 1;
  localparam int NBYTES = CNT_W / 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic [CNT_W-1:0]   result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               valid_q, valid_d;

  logic               edge_det;
  logic [TMR_W-1:0]   gate_load;
  logic [CNT_W-1:0]   cnt_next;
  logic               sat_next;

  osc_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .osc_in  (osc_in),
    .edge_det(edge_det)
  );

  // The final window cycle's edge is folded into the latched result via cnt_next.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    gate_load = TMR_W'(gate_len(gate_sel, GATE_MIN_LOG2) - 32'd1);
    cnt_next  = cnt_q;
    sat_next  = sat_q;

    if (edge_det) begin
      if (cnt_q == CNT_MAX) begin
        sat_next = 1'b1;
      end else begin
        cnt_next = cnt_q + CNT_W'(1);
      end
    end

    if (!ena) begin
      state_d = IDLE;
      timer_d = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = COUNT;
            timer_d = gate_load;
            cnt_d   = '0;
            sat_d   = 1'b0;
          end
        end
        COUNT: begin
          if (timer_q == '0) begin
            result_d = cnt_next;
            ovf_d    = sat_next;
            done_d   = 1'b1;
            valid_d  = 1'b1;
            cnt_d    = '0;
            sat_d    = 1'b0;
            if (continuous) begin
              timer_d = gate_load;
            end else begin
              state_d = IDLE;
              timer_d = '0;
            end
          end else begin
            timer_d = timer_q - TMR_W'(1);
            cnt_d   = cnt_next;
            sat_d   = sat_next;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
    end
  end

  // Bytes beyond the result width read as zero.
  always_comb begin
    data_out = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (byte_sel == BYTE_SEL_W'(i)) begin
        data_out = result_q[8*i +: 8];
      end
    end
  end

  assign result   = result_q;
  assign busy     = (state_q == COUNT);
  assign done     = done_q;
  assign valid    = valid_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_relax_osc_freq_counter.sv
// Directed and randomized checks of the frequency counter against an edge-counting model.
// Two instances (24-bit and 8-bit results) share all inputs.
module tb_relax_osc_freq_counter;

  localparam int SYNC = 2;
  localparam int HIST_N = 16384;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        osc_in = 1'b0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic [2:0]  gate_sel = 3'd0;
  logic [1:0]  byte_sel = 2'd0;

  logic [23:0] result;
  logic [7:0]  data_out;
  logic        busy, done, valid, overflow;
  logic [7:0]  result8;
  logic [7:0]  data_out8;
  logic        busy8, done8, valid8, overflow8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit hist [0:HIST_N-1];

  int   osc_half = 0;
  int   osc_cnt = 0;
  logic osc_force = 1'b0;

  relax_osc_freq_counter #(.CNT_W(24), .GATE_MIN_LOG2(8), .SYNC_STAGES(SYNC)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_in), .start(start),
    .continuous(continuous), .gate_sel(gate_sel), .byte_sel(byte_sel),
    .result(result), .data_out(data_out), .busy(busy), .done(done),
    .valid(valid), .overflow(overflow)
  );

  relax_osc_freq_counter #(.CNT_W(8), .GATE_MIN_LOG2(8), .SYNC_STAGES(SYNC)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_in), .start(start),
    .continuous(continuous), .gate_sel(gate_sel), .byte_sel(byte_sel),
    .result(result8), .data_out(data_out8), .busy(busy8), .done(done8),
    .valid(valid8), .overflow(overflow8)
  );

  always #5 clk = ~clk;

  // Oscillator source: square wave of osc_half clk cycles per level, or a forced level.
  always @(negedge clk) begin
    if (osc_half == 0) begin
      osc_in = osc_force;
    end else begin
      osc_cnt = osc_cnt + 1;
      if (osc_cnt >= osc_half) begin
        osc_cnt = 0;
        osc_in = ~osc_in;
      end
    end
  end

  // Record the oscillator level seen at every rising clk edge.
  always @(posedge clk) begin
    if (cyc < HIST_N) hist[cyc] = osc_in;
    cyc = cyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Rising osc edges become visible to the window SYNC cycles after they are sampled;
  // count those falling in the gate_len cycles following the start edge.
  function automatic int model_count(input int e0, input int len);
    int n = 0;
    for (int m = e0 + 1; m <= e0 + len; m++) begin
      if (hist[m-SYNC] && !hist[m-SYNC-1]) n++;
    end
    return n;
  endfunction

  task automatic applyStimulus(input logic [2:0] gsel, output int e0);
    gate_sel = gsel;
    start = 1'b1;
    e0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int done_cyc);
    done_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    if (done_cyc < 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL done_timeout observed no done expected done within %0d cycles", budget);
    end
  endtask

  task automatic verifyWindow(input string tag, input int e0, input int len, input int done_cyc);
    int n;
    int exp24;
    int exp8;
    int expb;
    if (done_cyc < 0) return;
    n = model_count(e0, len);
    exp24 = (n > 24'hFFFFFF) ? 24'hFFFFFF : n;
    exp8 = (n > 255) ? 255 : n;
    expb = (byte_sel < 2'd3) ? ((exp24 >> (8 * int'(byte_sel))) & 255) : 0;
    checkOutput({tag, "_latency"}, 32'(done_cyc - e0 - 1), 32'(len));
    checkOutput({tag, "_result"}, 32'(result), 32'(exp24));
    checkOutput({tag, "_overflow"}, 32'(overflow), 32'(n > 24'hFFFFFF));
    checkOutput({tag, "_valid"}, 32'(valid), 32'd1);
    checkOutput({tag, "_data_out"}, 32'(data_out), 32'(expb));
    checkOutput({tag, "_done8"}, 32'(done8), 32'd1);
    checkOutput({tag, "_result8"}, 32'(result8), 32'(exp8));
    checkOutput({tag, "_overflow8"}, 32'(overflow8), 32'(n > 255));
    checkOutput({tag, "_data_out8"}, 32'(data_out8), (byte_sel == 2'd0) ? 32'(exp8) : 32'd0);
  endtask

  initial begin
    int e0;
    int dc;
    int saw;
    logic [23:0] prev_result;
    logic        prev_ovf;
    logic [7:0]  t2_exp [4];
    t2_exp = '{8'h80, 8'h00, 8'h00, 8'h00};

    // Reset state
    tick(); tick(); tick();
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_data_out", 32'(data_out), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_valid", 32'(valid), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    ena = 1'b1;
    repeat (5) tick();

    // Period-16 oscillator, shortest window
    osc_half = 8;
    repeat (20) tick();
    applyStimulus(3'd0, e0);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    waitDone(300, dc);
    verifyWindow("t1", e0, 256, dc);
    checkOutput("t1_const", 32'(result), 32'd16);
    tick();
    checkOutput("t1_pulse", 32'(done), 32'd0);

    // Long window and byte readout
    applyStimulus(3'd3, e0);
    waitDone(2100, dc);
    verifyWindow("t2", e0, 2048, dc);
    for (int b = 0; b < 4; b++) begin
      byte_sel = 2'(b);
      #1;
      checkOutput("t2_byte", 32'(data_out), 32'(t2_exp[b]));
      if (b != 0) checkOutput("t2_byte8", 32'(data_out8), 32'd0);
    end
    byte_sel = 2'd0;

    // Oscillator at f_clk/2 saturates the 8-bit instance
    osc_half = 1;
    repeat (10) tick();
    applyStimulus(3'd1, e0);
    waitDone(600, dc);
    verifyWindow("t3", e0, 512, dc);
    checkOutput("t3_res8", 32'(result8), 32'hFF);
    checkOutput("t3_ovf8", 32'(overflow8), 32'd1);

    // Continuous back-to-back windows, gate_sel change takes effect next window
    osc_half = $urandom_range(2, 9);
    repeat (10) tick();
    continuous = 1'b1;
    applyStimulus(3'd0, e0);
    repeat (100) tick();
    gate_sel = 3'd1;
    waitDone(400, dc);
    verifyWindow("t4a", e0, 256, dc);
    checkOutput("t4a_busy", 32'(busy), 32'd1);
    e0 = dc - 1;
    tick();
    checkOutput("t4_pulse", 32'(done), 32'd0);
    waitDone(600, dc);
    verifyWindow("t4b", e0, 512, dc);
    checkOutput("t4b_busy", 32'(busy), 32'd1);
    e0 = dc - 1;
    continuous = 1'b0;
    waitDone(600, dc);
    verifyWindow("t4c", e0, 512, dc);
    checkOutput("t4c_busy", 32'(busy), 32'd0);

    // ena dropped mid-window: abort without touching the held result
    osc_half = 5;
    prev_result = result;
    prev_ovf = overflow;
    applyStimulus(3'd0, e0);
    repeat (128) tick();
    ena = 1'b0;
    tick();
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_done", 32'(done), 32'd0);
    saw = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (done === 1'b1) saw = 1;
    end
    checkOutput("t5_nodone", 32'(saw), 32'd0);
    checkOutput("t5_result", 32'(result), 32'(prev_result));
    checkOutput("t5_valid", 32'(valid), 32'd1);
    checkOutput("t5_overflow", 32'(overflow), 32'(prev_ovf));
    ena = 1'b1;
    repeat (3) tick();

    // Asynchronous reset in the middle of a window
    applyStimulus(3'd2, e0);
    repeat (10) tick();
    checkOutput("t5_busy_pre", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_result", 32'(result), 32'd0);
    checkOutput("arst_valid", 32'(valid), 32'd0);
    checkOutput("arst_overflow", 32'(overflow), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_done", 32'(done), 32'd0);
    checkOutput("arst_data_out", 32'(data_out), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (5) tick();

    // Single edge arriving on the last window cycle, then one cycle too late
    osc_half = 0;
    osc_force = 1'b0;
    repeat (10) tick();
    applyStimulus(3'd0, e0);
    while (cyc < e0 + 256 - SYNC) tick();
    osc_force = 1'b1;
    waitDone(300, dc);
    verifyWindow("t6a", e0, 256, dc);
    checkOutput("t6a_one", 32'(result), 32'd1);
    osc_force = 1'b0;
    repeat (10) tick();
    applyStimulus(3'd0, e0);
    while (cyc < e0 + 256 - SYNC + 1) tick();
    osc_force = 1'b1;
    waitDone(300, dc);
    verifyWindow("t6b", e0, 256, dc);
    checkOutput("t6b_zero", 32'(result), 32'd0);

    // Randomized oscillator rates, windows and byte selects
    for (int r = 0; r < 4; r++) begin
      osc_force = 1'b0;
      osc_half = $urandom_range(1, 12);
      byte_sel = 2'($urandom_range(0, 3));
      repeat (8) tick();
      applyStimulus(3'($urandom_range(0, 1)), e0);
      waitDone(600, dc);
      verifyWindow("rnd", e0, 256 << int'(gate_sel), dc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
